// File: rtl/addr_reg_bank.sv
// Address register bank: NREG address registers with a tri-state address bus, byte access
// over a tri-state data bus, +/-1 stepping and PC auto-increment. Optional SP wrap guard: ADDR_REG_BANK_SP_GUARD_EN.
module addr_reg_bank #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int NREG = 8,
  parameter int SW = $clog2(NREG),
  parameter int SP_IDX = 3,
  parameter int LR_IDX = 4,
  parameter logic [AW-1:0] SP_RESET = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [AW-1:0] abus,
  inout  wire  [DW-1:0] mbus,
  input  logic          aout_en,
  input  logic [SW-1:0] aout_sel,
  input  logic          aload_en,
  input  logic [SW-1:0] aload_sel,
  input  logic          mout_en,
  input  logic          mload_en,
  input  logic [SW-1:0] m_sel,
  input  logic          m_hi,
  input  logic          step_en,
  input  logic [SW-1:0] step_sel,
  input  logic          step_dir,
  input  logic          pc_count,
  output logic          sp_fault
);

  logic [AW-1:0] r_regs [NREG];
  logic [AW-1:0] w_next [NREG];
  logic [AW-1:0] w_aout;
  logic [AW-1:0] w_abus_in;
  logic [DW-1:0] w_mbyte;
  logic [DW-1:0] w_mbus_in;

  assign w_aout  = r_regs[aout_sel];
  assign w_mbyte = m_hi ? r_regs[m_sel][AW-1:DW] : r_regs[m_sel][DW-1:0];

  assign abus = aout_en ? w_aout  : {AW{1'bz}};
  assign mbus = mout_en ? w_mbyte : {DW{1'bz}};

  // While we drive a bus, our own value is what sits on it (single driver per bus).
  assign w_abus_in = aout_en ? w_aout  : abus;
  assign w_mbus_in = mout_en ? w_mbyte : mbus;

`ifdef ADDR_REG_BANK_SP_GUARD_EN
  logic w_sp_step;
  logic w_sp_wrap;
  logic r_sp_fault;

  // Only a step that actually wins priority on SP can fault.
  assign w_sp_step = step_en && (step_sel == SW'(SP_IDX))
                     && !(aload_en && (aload_sel == SW'(SP_IDX)))
                     && !(mload_en && (m_sel == SW'(SP_IDX)));
  assign w_sp_wrap = w_sp_step && (step_dir ? (r_regs[SP_IDX] == '0)
                                            : (r_regs[SP_IDX] == '1));
`endif

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_next[i] = r_regs[i];
      if (aload_en && (aload_sel == SW'(i))) begin
        w_next[i] = w_abus_in;
      end else if (mload_en && (m_sel == SW'(i))) begin
        if (m_hi) w_next[i][AW-1:DW] = w_mbus_in;
        else      w_next[i][DW-1:0]  = w_mbus_in;
      end else if (step_en && (step_sel == SW'(i))) begin
        if (i != LR_IDX) w_next[i] = step_dir ? (r_regs[i] - AW'(1)) : (r_regs[i] + AW'(1));
      end else if ((i == 0) && aout_en && (aout_sel == '0) && pc_count) begin
        w_next[i] = r_regs[i] + AW'(1);
      end
    end
`ifdef ADDR_REG_BANK_SP_GUARD_EN
    if (w_sp_wrap) w_next[SP_IDX] = r_regs[SP_IDX];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= w_next[i];
    end
  end

`ifdef ADDR_REG_BANK_SP_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_sp_fault <= 1'b0;
    else if (w_sp_wrap) r_sp_fault <= 1'b1;
  end
  assign sp_fault = r_sp_fault;
`else
  assign sp_fault = 1'b0;
`endif

endmodule
